ga_mutate: RTL
==============

GA_MUTATE -- requirements
Module: ga_mutate

Interface
REQ-001 SHALL have parameter GENOME_W, 25, bits per individual.
REQ-002 SHALL have parameter NUM_IND, 300, individuals per population.
REQ-003 SHALL have parameter MUT_RATE, 8'd13, mutation threshold; individual mutates when rnd8 < MUT_RATE.
REQ-004 SHALL have parameter LFSR_SEED, 16'hACE1, nonzero LFSR reset value.
REQ-005 SHALL have port clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port sel_pop, input, 7501, selected population; individual i at bits [i*GENOME_W +: GENOME_W]; bit 7500 is spare.
REQ-008 SHALL have port mut_start, input, 1, level request, held high by the GA controller while in its mutation state.
REQ-009 SHALL have port mut_pop, output, 7501, mutated population from the internal work register.
REQ-010 SHALL have port mut_done, output, 1, level completion flag.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: when mut_start=1 at a clock edge, SHALL copy sel_pop into the work register, clear idx to 0, and go to RUN.
REQ-013 RUN: each edge SHALL process individual idx, increment idx, and advance the LFSR one step.
REQ-014 Per individual: rnd8=lfsr[7:0], v=lfsr[12:8], pos=(v<GENOME_W)?v:v-GENOME_W; if rnd8<MUT_RATE, SHALL invert bit pos of the individual, otherwise leave it unchanged.
REQ-015 LFSR SHALL be a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, that advances only in RUN.
REQ-016 After individual NUM_IND-1 is processed, SHALL go to DONE; mut_done=1 exactly NUM_IND edges after the start-sampling edge.
REQ-017 DONE: mut_done SHALL stay 1 and mut_pop SHALL stay stable until mut_start=0, then return to IDLE with mut_done=0 on that edge.
REQ-018 mut_start falling during RUN (abort) SHALL return to IDLE next edge with mut_done kept 0; work register keeps the partially mutated contents and the LFSR keeps its state.
REQ-019 Bit 7500 of sel_pop SHALL pass through to mut_pop unmodified.
REQ-020 MUT_RATE=0 SHALL produce mut_pop==sel_pop; mut_pop SHALL change only in IDLE-load and RUN.
REQ-021 idx SHALL be $clog2(NUM_IND) bits wide and SHALL never address beyond NUM_IND-1.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=IDLE, idx=0, lfsr=LFSR_SEED, work register=0 (mut_pop=0), mut_done=0.
REQ-023 Reset asserted mid-RUN SHALL abandon the pass; after release the block SHALL wait in IDLE for mut_start.

Configuration
REQ-024 With macro GA_MUTATE_ELITE_EN defined, individual 0 SHALL be exempt from mutation (elitism); the LFSR still advances on its cycle.
REQ-025 Without GA_MUTATE_ELITE_EN, all NUM_IND individuals SHALL be eligible; no other behaviour differs.

Structure
REQ-026 Shared package ga_pkg SHALL hold POP_W=7501, GENOME_W, NUM_IND, the LFSR polynomial constant, and the FSM state enum.
REQ-027 The LFSR SHALL be a separate sub-module ga_lfsr16 (ports clk, rst_n, step, seed, q).

Verification
REQ-028 MUT_RATE=0, sel_pop=random, pulse mut_start -> mut_done high after exactly 300 edges, mut_pop==sel_pop.
REQ-029 MUT_RATE=255, sel_pop=0 -> every individual has popcount<=1; positions and counts match a bit-exact C model seeded 16'hACE1.
REQ-030 Hold mut_start high 5 cycles past mut_done, then drop -> mut_done falls on the same edge start is sampled low, and mut_pop stays stable throughout.
REQ-031 Drop mut_start at idx=100 -> IDLE next edge, mut_done never asserted; a restart reloads sel_pop and completes in 300 edges.
REQ-032 Assert rst_n=0 at idx=150 -> mut_pop=0, mut_done=0 immediately; the next run reproduces the seeded model from its first step.
REQ-033 GA_MUTATE_ELITE_EN defined, MUT_RATE=255 -> individual 0 unchanged, all others match the model.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared definitions for the GA mutation block: population geometry,
// LFSR feedback polynomial and the mutation FSM state encoding.
package ga_pkg;

  localparam int POP_W    = 7501;  // 300 x 25-bit genomes plus one spare bit
  localparam int GENOME_W = 25;
  localparam int NUM_IND  = 300;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ga_state_t;

  // One Galois step: shift right, fold the polynomial in when a 1 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit Galois LFSR that only advances when step is high.
// Reset reloads the seed so every pass after a reset is reproducible.
module ga_lfsr16
  import ga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // LFSR state register, held when not stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/ga_mutate.sv
// GA mutation stage: walks the selected population one individual per
// clock and, driven by an LFSR, flips at most one bit per individual.
// Optional build macro GA_MUTATE_ELITE_EN exempts individual 0 from
// mutation (elitism); the LFSR still steps on that cycle.
module ga_mutate
  import ga_pkg::*;
#(
  parameter int          GENOME_W  = ga_pkg::GENOME_W,
  parameter int          NUM_IND   = ga_pkg::NUM_IND,
  parameter logic [7:0]  MUT_RATE  = 8'd13,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POP_W-1:0] sel_pop,
  input  logic             mut_start,
  output logic [POP_W-1:0] mut_pop,
  output logic             mut_done
);

  localparam int IDX_W = $clog2(NUM_IND);
  localparam int BIT_W = $clog2(POP_W);

  ga_state_t        state;
  ga_state_t        state_next;
  logic [IDX_W-1:0] idx;
  logic [POP_W-1:0] work;
  logic [15:0]      lfsr_q;
  logic             lfsr_step;
  logic [7:0]       rnd8;
  logic [4:0]       v;
  logic [4:0]       pos;
  logic [BIT_W-1:0] bit_sel;
  logic             last;
  logic             elite;
  logic             do_flip;

  ga_lfsr16 u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .step (lfsr_step),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Random fields come from the LFSR value before this cycle's step.
  assign rnd8    = lfsr_q[7:0];
  assign v       = lfsr_q[12:8];
  assign pos     = (int'(v) < GENOME_W) ? v : v - 5'(GENOME_W);
  assign bit_sel = BIT_W'(idx) * BIT_W'(GENOME_W) + BIT_W'(pos);
  assign last    = (idx == IDX_W'(NUM_IND - 1));

`ifdef GA_MUTATE_ELITE_EN
  assign elite = (idx == '0);
`else
  assign elite = 1'b0;
`endif

  assign do_flip   = (rnd8 < MUT_RATE) && !elite;
  // An abort edge (start low in RUN) leaves the LFSR untouched.
  assign lfsr_step = (state == RUN) && mut_start;

  assign mut_pop  = work;
  assign mut_done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start level drives entry, exit and abort.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mut_start) state_next = RUN;
      RUN: begin
        if (!mut_start) begin
          state_next = IDLE;
        end else if (last) begin
          state_next = DONE;
        end
      end
      DONE:    if (!mut_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Work register and individual counter: load on start, one individual per RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mut_start) begin
            work <= sel_pop;
            idx  <= '0;
          end
        end
        RUN: begin
          if (mut_start) begin
            if (do_flip) begin
              work[bit_sel] <= ~work[bit_sel];
            end
            idx <= last ? '0 : idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
